mips32_run_control: RTL and testbench
=====================================

MIPS32_RUN_CONTROL -- requirements
Module: mips32_run_control

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CORES, 1, number of controlled cores/channels
- RESET_CYCLES, 2, cycles core reset is held low
- MAX_CYCLES, 9, run-cycle budget before timeout
- CNT_WIDTH, 16, cycle counter width
REQ-002 Parameter constraints SHALL be: MAX_CYCLES <= 2^CNT_WIDTH-1; RESET_CYCLES >= 1; NUM_CORES >= 1.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on rising edge
- reset_n, in, 1, synchronous active-low reset
- start, in, 1, launch run (level sampled per cycle)
- abort, in, 1, cancel run, return to idle
- halt_in, in, NUM_CORES, per-core halt indication
- core_rst_n, out, 1, active-low reset to cores
- core_en, out, NUM_CORES, per-core clock enable
- cycle_count, out, CNT_WIDTH, run cycles elapsed
- halted_mask, out, NUM_CORES, sticky per-core halted flags
- busy, out, 1, high in RST_HOLD or RUN
- done, out, 1, high in DONE
- timeout, out, 1, high in DONE when budget exhausted
REQ-004 One clock; reset is synchronous and active-low (reset_n sampled only on the rising edge of clock).

Function
REQ-005 FSM SHALL have states IDLE, RST_HOLD, RUN, DONE; all outputs registered.
REQ-006 IDLE: core_rst_n=0, core_en=0, busy=0; start=1 -> RST_HOLD next cycle; cycle_count and halted_mask cleared on that transition; done and timeout cleared on leaving DONE or IDLE.
REQ-007 RST_HOLD: core_rst_n=0, core_en=0, busy=1 for exactly RESET_CYCLES cycles, then RUN.
REQ-008 RUN: core_rst_n=1; core_en[i] = ~halted_mask[i]; cycle_count increments by 1 each RUN cycle, starting at 0 in the first RUN cycle.
REQ-009 halted_mask[i] SHALL set on the edge where state=RUN, core_en[i]=1 and halt_in[i]=1; sticky until next start; halt_in ignored outside RUN.
REQ-010 RUN -> DONE with timeout=0 on the edge where all halted_mask bits (including those set on that edge) are 1.
REQ-011 RUN -> DONE with timeout=1 when cycle_count = MAX_CYCLES-1 and not all cores halted; cycle_count SHALL not exceed MAX_CYCLES-1.
REQ-012 Simultaneous last halt and budget expiry SHALL resolve to done=1, timeout=0 (halt wins).
REQ-013 DONE: core_rst_n=1, core_en=0, done=1, cycle_count and halted_mask frozen; start=1 -> RST_HOLD (restart); otherwise stay.
REQ-014 start SHALL be ignored in RST_HOLD and RUN.
REQ-015 abort=1 in RST_HOLD, RUN or DONE -> IDLE next cycle, done=0, timeout=0, cycle_count frozen; abort has priority over start and over RUN exit conditions.
REQ-016 Latency: start sampled at edge k -> busy=1 from k+1; first core_en=1 at edge k+1+RESET_CYCLES.

Reset
REQ-017 reset_n=0 at an edge SHALL force IDLE: core_rst_n=0, core_en=0, cycle_count=0, halted_mask=0, busy=0, done=0, timeout=0, from any state including mid-run; reset has priority over start and abort.
REQ-018 Asynchronous changes of reset_n between edges SHALL have no effect.

Verification
REQ-019 Reset, start pulse, no halts (defaults) -> busy 2 cycles RST_HOLD, core_en=1 for 9 cycles, done=1, timeout=1, cycle_count=8.
REQ-020 NUM_CORES=1, halt_in=1 in 4th RUN cycle -> done=1, timeout=0, cycle_count=3, halted_mask=1, core_en=0 next cycle.
REQ-021 NUM_CORES=4, halts on cores 0,2 at RUN cycle 1, cores 1,3 at RUN cycle 8 -> core_en=4'b1010 after cycle 1, done=1, timeout=0 (halt wins at budget limit).
REQ-022 abort=1 together with start=1 during RUN at cycle_count=5 -> IDLE next cycle, busy=0, done=0, cycle_count=5.
REQ-023 reset_n=0 mid-RUN at cycle_count=6 -> all outputs at reset values next edge; later start restarts with cycle_count=0.
REQ-024 reset_n glitch low between edges during RUN -> no state or output change.

Source files
------------

// File: rtl/mips32_run_control.sv
// ---------------------------------------------------------------------------
// mips32_run_control
//
// Run controller for one or more simulated MIPS32 cores. On a start request
// it holds the cores in reset for a fixed number of cycles, then enables
// them and counts run cycles. Each core is stopped individually when it
// reports a halt. The run ends when every core has halted, or with a
// timeout flag when the cycle budget runs out. An abort returns the
// controller to idle at any point.
//
// Parameters
//   NUM_CORES    number of controlled cores (>= 1)
//   RESET_CYCLES cycles core_rst_n is held low before the run (>= 1)
//   MAX_CYCLES   run-cycle budget (1 .. 2^CNT_WIDTH-1)
//   CNT_WIDTH    width of the run-cycle counter
//
// Ports
//   clock        single clock, rising edge
//   reset_n      synchronous active-low reset
//   start        launch a run (level sampled in IDLE and DONE)
//   abort        cancel a run and return to IDLE
//   halt_in      per-core halt indication, only looked at in RUN
//   core_rst_n   active-low reset driven to the cores
//   core_en      per-core clock enable
//   cycle_count  run cycles elapsed (0 in the first RUN cycle)
//   halted_mask  sticky per-core halted flags
//   busy         high in RST_HOLD or RUN
//   done         high in DONE
//   timeout      high in DONE when the budget was exhausted
//
// Every output comes straight from a flop: the next-state logic computes
// the next value of each output from the next state.
// ---------------------------------------------------------------------------
module mips32_run_control #(
  parameter int NUM_CORES    = 1,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 9,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] halt_in,
  output logic                 core_rst_n,
  output logic [NUM_CORES-1:0] core_en,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [NUM_CORES-1:0] halted_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [HOLD_W-1:0]      hold_reg, hold_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic [NUM_CORES-1:0]   mask_reg, mask_next;
  logic [NUM_CORES-1:0]   en_reg, en_next;
  logic                   rst_n_reg, rst_n_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   timeout_reg, timeout_next;
  logic [NUM_CORES-1:0]   mask_upd;

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      count_reg   <= '0;
      mask_reg    <= '0;
      en_reg      <= '0;
      rst_n_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      count_reg   <= count_next;
      mask_reg    <= mask_next;
      en_reg      <= en_next;
      rst_n_reg   <= rst_n_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    count_next   = count_reg;
    mask_next    = mask_reg;
    timeout_next = timeout_reg;

    // A halt only counts for a core that is still enabled; en_reg is zero
    // outside RUN, so halt_in is ignored there automatically.
    mask_upd = mask_reg | (halt_in & en_reg);

    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next   = RST_HOLD;
          hold_next    = '0;
          count_next   = '0;
          mask_next    = '0;
          timeout_next = 1'b0;
        end
      end
      RST_HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = RUN;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      RUN: begin
        mask_next = mask_upd;
        // Completion is tested before the budget so that a final halt on
        // the last budget cycle is reported as a clean finish.
        if (&mask_upd) begin
          state_next   = DONE;
          timeout_next = 1'b0;
        end else if (count_reg == CNT_LAST) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end else begin
          count_next = count_reg + CNT_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides start and any RUN exit; counter and mask freeze.
    if (abort && state_reg != IDLE) begin
      state_next   = IDLE;
      hold_next    = hold_reg;
      count_next   = count_reg;
      mask_next    = mask_reg;
      timeout_next = 1'b0;
    end

    // Outputs for the coming cycle. mask_next is already zero when RUN is
    // entered from RST_HOLD, so ~mask_next covers both entry and staying.
    en_next    = (state_next == RUN) ? ~mask_next : '0;
    rst_n_next = (state_next == RUN) || (state_next == DONE);
    busy_next  = (state_next == RST_HOLD) || (state_next == RUN);
    done_next  = (state_next == DONE);
  end

  assign core_rst_n  = rst_n_reg;
  assign core_en     = en_reg;
  assign cycle_count = count_reg;
  assign halted_mask = mask_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_mips32_run_control.sv
// ---------------------------------------------------------------------------
// tb_mips32_run_control
//
// Directed bench for mips32_run_control. One instance uses the default
// parameters (single core, 2 reset cycles, budget 9); a second instance
// uses four cores for the multi-core halt scenario. Inputs change 1 time
// unit after a rising edge and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_mips32_run_control;

  logic clock = 1'b0;
  logic reset_n;

  // Single-core instance
  logic        start, abort;
  logic [0:0]  halt_in;
  logic        core_rst_n;
  logic [0:0]  core_en;
  logic [15:0] cycle_count;
  logic [0:0]  halted_mask;
  logic        busy, done, timeout;

  // Four-core instance
  logic        start4, abort4;
  logic [3:0]  halt4;
  logic        rst4_n;
  logic [3:0]  en4;
  logic [15:0] cnt4;
  logic [3:0]  mask4;
  logic        busy4, done4, to4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mips32_run_control dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .halt_in     (halt_in),
    .core_rst_n  (core_rst_n),
    .core_en     (core_en),
    .cycle_count (cycle_count),
    .halted_mask (halted_mask),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  mips32_run_control #(.NUM_CORES(4)) dut4 (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start4),
    .abort       (abort4),
    .halt_in     (halt4),
    .core_rst_n  (rst4_n),
    .core_en     (en4),
    .cycle_count (cnt4),
    .halted_mask (mask4),
    .busy        (busy4),
    .done        (done4),
    .timeout     (to4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;

    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; halt_in = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; halt4 = 4'b0;

    // Reset state
    tick(); tick();
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_en",    32'(core_en),    32'd0);
    check("rst_count",      32'(cycle_count), 32'd0);
    check("rst_mask",       32'(halted_mask), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_timeout",    32'(timeout),    32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Full timeout run, no halts
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_hold1_busy", 32'(busy), 32'd1);
    check("to_hold1_en",   32'(core_en), 32'd0);
    check("to_hold1_rstn", 32'(core_rst_n), 32'd0);
    tick();
    check("to_hold2_busy", 32'(busy), 32'd1);
    check("to_hold2_en",   32'(core_en), 32'd0);
    tick();
    check("to_run0_en",    32'(core_en), 32'd1);
    check("to_run0_rstn",  32'(core_rst_n), 32'd1);
    check("to_run0_count", 32'(cycle_count), 32'd0);
    n = 0; guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      if (core_en === 1'b1) n++;
      tick();
      guard++;
    end
    check("to_done_reached", 32'(done), 32'd1);
    check("to_en_cycles",    32'(n), 32'd9);
    check("to_timeout",      32'(timeout), 32'd1);
    check("to_count",        32'(cycle_count), 32'd8);
    check("to_busy",         32'(busy), 32'd0);
    check("to_en_off",       32'(core_en), 32'd0);
    check("to_rstn_done",    32'(core_rst_n), 32'd1);
    tick();
    check("to_done_holds",   32'(done), 32'd1);
    check("to_count_frozen", 32'(cycle_count), 32'd8);

    // Restart from DONE, halt in the 4th RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("h_restart_busy",  32'(busy), 32'd1);
    check("h_restart_done",  32'(done), 32'd0);
    check("h_restart_to",    32'(timeout), 32'd0);
    check("h_restart_count", 32'(cycle_count), 32'd0);
    tick(); tick();
    tick(); tick(); tick();
    check("h_run3_count", 32'(cycle_count), 32'd3);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    check("h_done",    32'(done), 32'd1);
    check("h_timeout", 32'(timeout), 32'd0);
    check("h_count",   32'(cycle_count), 32'd3);
    check("h_mask",    32'(halted_mask), 32'd1);
    check("h_en_off",  32'(core_en), 32'd0);

    // Start ignored in RUN; abort with start at count 5
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_restart_mask", 32'(halted_mask), 32'd0);
    tick(); tick();
    tick(); tick();
    check("a_run2_count", 32'(cycle_count), 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_start_ign_count", 32'(cycle_count), 32'd3);
    check("a_start_ign_busy",  32'(busy), 32'd1);
    tick(); tick();
    check("a_run5_count", 32'(cycle_count), 32'd5);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("a_busy",  32'(busy), 32'd0);
    check("a_done",  32'(done), 32'd0);
    check("a_to",    32'(timeout), 32'd0);
    check("a_count", 32'(cycle_count), 32'd5);
    check("a_rstn",  32'(core_rst_n), 32'd0);
    check("a_en",    32'(core_en), 32'd0);
    tick();
    check("a_idle_stays", 32'(busy), 32'd0);

    // Halt ignored outside RUN; reset mid-run at count 6
    start = 1'b1; halt_in = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    halt_in = 1'b0;
    check("r_run0_mask",  32'(halted_mask), 32'd0);
    check("r_run0_en",    32'(core_en), 32'd1);
    check("r_run0_count", 32'(cycle_count), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("r_run6_count", 32'(cycle_count), 32'd6);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("r_rstn",  32'(core_rst_n), 32'd0);
    check("r_en",    32'(core_en), 32'd0);
    check("r_count", 32'(cycle_count), 32'd0);
    check("r_busy",  32'(busy), 32'd0);
    check("r_done",  32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("r_again_count", 32'(cycle_count), 32'd0);
    check("r_again_en",    32'(core_en), 32'd1);

    // reset_n glitch between edges during RUN
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    check("g_count", 32'(cycle_count), 32'd1);
    check("g_busy",  32'(busy), 32'd1);
    check("g_en",    32'(core_en), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("g_abort_busy", 32'(busy), 32'd0);

    // Four cores: 0,2 halt at RUN cycle 1, 1,3 at the last budget cycle
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    check("m_run0_en", 32'(en4), 32'hF);
    tick();
    check("m_run1_count", 32'(cnt4), 32'd1);
    halt4 = 4'b0101;
    tick();
    halt4 = 4'b0000;
    check("m_en_after", 32'(en4), 32'b1010);
    check("m_mask_after", 32'(mask4), 32'b0101);
    for (int i = 0; i < 6; i++) tick();
    check("m_run8_count", 32'(cnt4), 32'd8);
    check("m_run8_en",    32'(en4), 32'b1010);
    halt4 = 4'b1010;
    tick();
    halt4 = 4'b0000;
    check("m_done",    32'(done4), 32'd1);
    check("m_timeout", 32'(to4), 32'd0);
    check("m_mask",    32'(mask4), 32'hF);
    check("m_count",   32'(cnt4), 32'd8);
    check("m_en_off",  32'(en4), 32'd0);
    check("m_busy",    32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
